ctrl_sequencer: RTL and testbench
=================================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 ins_valid  in  1  fetch presents an instruction; ins_ready  out  1  sequencer accepts one.
REQ-005 ins_opcode  in  4  opcode of the presented instruction.
REQ-006 rom_opcode  out  4  registered opcode driven to the decode ROM.
REQ-007 rom_alu  in  8 and rom_ctrl  in  16  decode ROM outputs, combinational from rom_opcode.
REQ-008 cond_nz  in  1  branch condition: decremented register is non-zero.
REQ-009 mem_req  out  1, mem_we  out  1, mem_byte  out  1, mem_ack  in  1  data-memory handshake.
REQ-010 alu_op  out  8  latched ALU flags (ci nb ic na xo no rot -).
REQ-011 use_imm  out  1, reg_we  out  1, wb_sel  out  2 (0 ALU, 1 mem, 2 link PC, 3 upper imm).
REQ-012 pc_we  out  1, pc_rel  out  1, scr_we  out  1, retire  out  1, mem_err  out  1.

Function
REQ-013 ctrl bit map SHALL be: 0 LDI, 1 MR, 2 MW, 3 SPC, 4 WPC, 5 PCREL, 6 IMM, 7 COND, 8 BYTE, 9 LUI, 10 SCR; bits 15:11 SHALL be ignored.
REQ-014 States SHALL be IDLE, DECODE, EXEC, MEM, WB.
REQ-015 IDLE: ins_ready=1; when ins_valid=1, SHALL latch ins_opcode into rom_opcode and go to DECODE.
REQ-016 DECODE: SHALL latch rom_alu and rom_ctrl into internal registers and go to EXEC; ins_ready=0 in every state except IDLE.
REQ-017 EXEC: alu_op and use_imm (IMM) SHALL be driven; if MR or MW, go to MEM; otherwise go to WB.
REQ-018 MEM: mem_req=1, mem_we=MW, mem_byte=BYTE, held stable until mem_ack=1; on ack go to WB on the next edge.
REQ-019 A 8-bit wait counter SHALL count MEM cycles; after 255 cycles without ack, mem_err SHALL set (sticky), mem_req SHALL drop, and the FSM SHALL go to WB with reg_we suppressed.
REQ-020 mem_ack outside MEM SHALL be ignored.
REQ-021 WB is one cycle; retire=1 for exactly that cycle; then return to IDLE.
REQ-022 In WB, reg_we SHALL be 1 unless MW=1 or (MR=1 and the access timed out).
REQ-023 wb_sel precedence SHALL be: SPC->2, MR->1, LUI->3, otherwise 0.
REQ-024 pc_we SHALL be 1 in WB when WPC=1 and (COND=0 or cond_nz=1); pc_rel=PCREL.
REQ-025 scr_we SHALL be 1 in WB when SCR=1.
REQ-026 Latency: a non-memory instruction accepted at edge N SHALL retire in the cycle after edge N+2; ins_ready SHALL be 1 again after edge N+3.
REQ-027 A memory instruction SHALL retire one cycle after the ack edge.
REQ-028 Outside their stated states, mem_req, reg_we, pc_we, scr_we and retire SHALL be 0.

Reset
REQ-029 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE and rom_opcode, latched flags, wait counter and mem_err SHALL be cleared.
REQ-030 Reset SHALL take effect from any state, including MEM, and SHALL drop mem_req from the next cycle.
REQ-031 An instruction in flight at reset SHALL not retire.

Structure
REQ-032 The ctrl bit indices, state enum and wb_sel encodings SHALL live in the shared package scd_pkg.
REQ-033 The MEM timeout counter SHALL be a sub-module, mem_watchdog (inputs clear, enable; output expired).

Verification
REQ-034 add (0x0), ins_valid for 1 cycle -> rom_opcode=0x0, alu_op=0x00, reg_we=1, wb_sel=0, retire 3 cycles after accept.
REQ-035 ldb (0xE), mem_ack 4 cycles after mem_req -> mem_req=1, mem_we=0, mem_byte=1 for 4 cycles; wb_sel=1, reg_we=1.
REQ-036 b-- (0x9) -> with cond_nz=1: pc_we=1, pc_rel=1, reg_we=1; with cond_nz=0: pc_we=0.
REQ-037 stb (0xD), no ack -> mem_err=1 after 255 MEM cycles, reg_we=0, retire=1, next instruction accepted.
REQ-038 rst_n=0 during MEM -> IDLE, mem_req=0, no retire, ins_ready=1.
REQ-039 jlr (0x7) -> wb_sel=2, reg_we=1, pc_we=1, pc_rel=0.

Source files
------------

// File: rtl/scd_pkg.sv
// Shared definitions for the control sequencer: ctrl-word bit map, FSM states,
// write-back select encodings and the memory timeout length.
package scd_pkg;

    localparam int CTRL_W      = 16;
    localparam int CTRL_USED   = 11;
    localparam int ALU_W       = 8;
    localparam int MEM_TIMEOUT = 255;

    localparam int C_LDI   = 0;
    localparam int C_MR    = 1;
    localparam int C_MW    = 2;
    localparam int C_SPC   = 3;
    localparam int C_WPC   = 4;
    localparam int C_PCREL = 5;
    localparam int C_IMM   = 6;
    localparam int C_COND  = 7;
    localparam int C_BYTE  = 8;
    localparam int C_LUI   = 9;
    localparam int C_SCR   = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_LINK  = 2'd2;
    localparam logic [1:0] WB_UPPER = 2'd3;

    // Link-PC beats memory data, which beats upper-immediate.
    function automatic logic [1:0] wb_sel_of(input logic [CTRL_USED-1:0] c);
        if (c[C_SPC])      return WB_LINK;
        else if (c[C_MR])  return WB_MEM;
        else if (c[C_LUI]) return WB_UPPER;
        else               return WB_ALU;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive enabled cycles; expired flags the last allowed cycle so the
// owner can abandon the access on that same edge.
module mem_watchdog
    import scd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) cnt <= '0;
        else if (enable)     cnt <= cnt + 8'd1;
    end

    assign expired = enable && (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer: fetch handshake, decode-ROM latch, optional
// data-memory access with watchdog, and a one-cycle write-back/retire.
module ctrl_sequencer
    import scd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [3:0]        ins_opcode,
    output logic [3:0]        rom_opcode,
    input  logic [ALU_W-1:0]  rom_alu,
    input  logic [CTRL_W-1:0] rom_ctrl,
    input  logic              cond_nz,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_byte,
    input  logic              mem_ack,
    output logic [ALU_W-1:0]  alu_op,
    output logic              use_imm,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic              pc_we,
    output logic              pc_rel,
    output logic              scr_we,
    output logic              retire,
    output logic              mem_err
);

    state_t               state;
    logic [ALU_W-1:0]     alu_q;
    logic [CTRL_USED-1:0] ctrl_q;
    logic                 wpc_q;
    logic                 expired;
    logic                 is_mem;
    logic                 enter_wb;
    logic                 xfer_ok;
    logic                 unused_ctrl_hi;

    assign unused_ctrl_hi = ^rom_ctrl[CTRL_W-1:CTRL_USED];

    mem_watchdog u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != S_MEM),
        .enable  (state == S_MEM),
        .expired (expired)
    );

    assign is_mem   = ctrl_q[C_MR] | ctrl_q[C_MW];
    assign enter_wb = ((state == S_EXEC) && !is_mem) ||
                      ((state == S_MEM) && (mem_ack || expired));
    // Only a timed-out access reaches WB from MEM without an ack.
    assign xfer_ok  = !((state == S_MEM) && !mem_ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ins_ready  <= 1'b1;
            rom_opcode <= '0;
            alu_q      <= '0;
            ctrl_q     <= '0;
            mem_req    <= 1'b0;
            mem_err    <= 1'b0;
            retire     <= 1'b0;
            reg_we     <= 1'b0;
            wb_sel     <= WB_ALU;
            wpc_q      <= 1'b0;
            scr_we     <= 1'b0;
        end else begin
            retire <= 1'b0;
            reg_we <= 1'b0;
            wb_sel <= WB_ALU;
            wpc_q  <= 1'b0;
            scr_we <= 1'b0;
            case (state)
                S_IDLE: if (ins_valid) begin
                    rom_opcode <= ins_opcode;
                    ins_ready  <= 1'b0;
                    state      <= S_DECODE;
                end
                S_DECODE: begin
                    alu_q  <= rom_alu;
                    ctrl_q <= rom_ctrl[CTRL_USED-1:0];
                    state  <= S_EXEC;
                end
                S_EXEC: if (is_mem) begin
                    mem_req <= 1'b1;
                    state   <= S_MEM;
                end
                S_MEM: if (mem_ack) begin
                    mem_req <= 1'b0;
                end else if (expired) begin
                    mem_req <= 1'b0;
                    mem_err <= 1'b1;
                end
                S_WB: begin
                    ins_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    ins_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
            if (enter_wb) begin
                state  <= S_WB;
                retire <= 1'b1;
                reg_we <= !ctrl_q[C_MW] && xfer_ok;
                wb_sel <= wb_sel_of(ctrl_q);
                wpc_q  <= ctrl_q[C_WPC];
                scr_we <= ctrl_q[C_SCR];
            end
        end
    end

    // Branch condition is evaluated live during the WB cycle.
    assign pc_we    = wpc_q && (!ctrl_q[C_COND] || cond_nz);
    assign pc_rel   = ctrl_q[C_PCREL];
    assign alu_op   = alu_q;
    assign use_imm  = ctrl_q[C_IMM];
    assign mem_we   = mem_req && ctrl_q[C_MW];
    assign mem_byte = mem_req && ctrl_q[C_BYTE];

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: the driver queues expected retire records,
// a negedge monitor pops and compares them whenever retire is seen.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [3:0]  ins_opcode = 4'h0;
    logic [3:0]  rom_opcode;
    logic [7:0]  rom_alu;
    logic [15:0] rom_ctrl;
    logic        cond_nz = 1'b0;
    logic        mem_req, mem_we, mem_byte;
    logic        mem_ack = 1'b0;
    logic [7:0]  alu_op;
    logic        use_imm, reg_we, pc_we, pc_rel, scr_we, retire, mem_err;
    logic [1:0]  wb_sel;

    ctrl_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_opcode(ins_opcode), .rom_opcode(rom_opcode), .rom_alu(rom_alu),
        .rom_ctrl(rom_ctrl), .cond_nz(cond_nz), .mem_req(mem_req), .mem_we(mem_we),
        .mem_byte(mem_byte), .mem_ack(mem_ack), .alu_op(alu_op), .use_imm(use_imm),
        .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_rel(pc_rel),
        .scr_we(scr_we), .retire(retire), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Decode ROM model: bits 15:11 of lui carry junk that must be ignored.
    always_comb begin
        rom_alu  = 8'h00;
        rom_ctrl = 16'h0000;
        case (rom_opcode)
            4'h0: begin rom_alu = 8'h00; rom_ctrl = 16'h0000; end // add
            4'h3: begin rom_alu = 8'h21; rom_ctrl = 16'hFE01; end // lui: LDI LUI SCR
            4'h5: begin rom_alu = 8'h40; rom_ctrl = 16'h0208; end // SPC+LUI
            4'h6: begin rom_alu = 8'h02; rom_ctrl = 16'h0202; end // MR+LUI
            4'h7: begin rom_alu = 8'h00; rom_ctrl = 16'h0018; end // jlr
            4'h9: begin rom_alu = 8'h0C; rom_ctrl = 16'h00B0; end // b--
            4'hC: begin rom_alu = 8'h80; rom_ctrl = 16'h0002; end // ldw
            4'hD: begin rom_alu = 8'h81; rom_ctrl = 16'h0144; end // stb
            4'hE: begin rom_alu = 8'h81; rom_ctrl = 16'h0142; end // ldb
            default: ;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] alu;
        logic       imm;
        logic [1:0] wbsel;
        logic       regwe, pcwe, pcrel, scrwe, err;
        int         memcyc;
        logic       mwe, mbyte;
        int         ret_cyc;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [7:0] alu, input logic imm,
                                input logic [1:0] wbsel, input logic regwe, input logic pcwe,
                                input logic pcrel, input logic scrwe, input logic err,
                                input int memcyc, input logic mwe, input logic mbyte);
        exp_t e;
        e.op = op; e.alu = alu; e.imm = imm; e.wbsel = wbsel; e.regwe = regwe;
        e.pcwe = pcwe; e.pcrel = pcrel; e.scrwe = scrwe; e.err = err;
        e.memcyc = memcyc; e.mwe = mwe; e.mbyte = mbyte; e.ret_cyc = 0;
        return e;
    endfunction

    // Memory responder: acks in the ack_delay-th cycle of mem_req (0 = never).
    int   ack_delay = 0;
    logic stray = 1'b0;
    int   mcnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            mcnt++;
            mem_ack = (ack_delay != 0) && (mcnt == ack_delay);
        end else begin
            mcnt = 0;
            mem_ack = stray;
        end
    end

    // Monitor
    int   mon_mc = 0;
    logic mon_we = 1'b0, mon_by = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ins_ready) mon_mc = 0;
            if (mem_req) begin
                mon_mc++;
                mon_we = mem_we;
                mon_by = mem_byte;
            end
            if (retire) begin
                if (q.size() == 0) begin
                    check("unexpected_retire", 32'(retire), 32'd0);
                end else begin
                    me = q.pop_front();
                    check($sformatf("op%h_rom_opcode", me.op), 32'(rom_opcode), 32'(me.op));
                    check($sformatf("op%h_alu_op", me.op),     32'(alu_op),     32'(me.alu));
                    check($sformatf("op%h_use_imm", me.op),    32'(use_imm),    32'(me.imm));
                    check($sformatf("op%h_wb_sel", me.op),     32'(wb_sel),     32'(me.wbsel));
                    check($sformatf("op%h_reg_we", me.op),     32'(reg_we),     32'(me.regwe));
                    check($sformatf("op%h_pc_we", me.op),      32'(pc_we),      32'(me.pcwe));
                    check($sformatf("op%h_pc_rel", me.op),     32'(pc_rel),     32'(me.pcrel));
                    check($sformatf("op%h_scr_we", me.op),     32'(scr_we),     32'(me.scrwe));
                    check($sformatf("op%h_mem_err", me.op),    32'(mem_err),    32'(me.err));
                    check($sformatf("op%h_mem_req_off", me.op), 32'(mem_req),   32'd0);
                    check($sformatf("op%h_retire_cycle", me.op), 32'(cyc),      32'(me.ret_cyc));
                    check($sformatf("op%h_mem_cycles", me.op), 32'(mon_mc),     32'(me.memcyc));
                    if (me.memcyc > 0) begin
                        check($sformatf("op%h_mem_we", me.op),   32'(mon_we), 32'(me.mwe));
                        check($sformatf("op%h_mem_byte", me.op), 32'(mon_by), 32'(me.mbyte));
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input exp_t e, input int delay, input bit push);
        exp_t ee;
        int t;
        t = 0;
        while (!ins_ready && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        if (!ins_ready) check("ready_timeout", 32'(ins_ready), 32'd1);
        ee = e;
        ee.ret_cyc = cyc + 1 + 2 + e.memcyc;
        ack_delay  = delay;
        ins_opcode = op;
        ins_valid  = 1'b1;
        if (push) q.push_back(ee);
        @(negedge clk); #1;
        ins_valid  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk); #1;
        check("ready_after_wb", 32'(ins_ready), 32'd1);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ins_ready", 32'(ins_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_rom_opcode", 32'(rom_opcode), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        //                op    alu    imm wbsel rwe pwe prl scr err mc  mwe mby
        issue(4'h0, mk(4'h0, 8'h00, 0, 2'd0, 1, 0, 0, 0, 0, 0,   0, 0), 0, 1); drain();
        stray = 1'b1;
        issue(4'h0, mk(4'h0, 8'h00, 0, 2'd0, 1, 0, 0, 0, 0, 0,   0, 0), 0, 1); drain();
        stray = 1'b0;
        issue(4'h3, mk(4'h3, 8'h21, 0, 2'd3, 1, 0, 0, 1, 0, 0,   0, 0), 0, 1); drain();
        issue(4'hE, mk(4'hE, 8'h81, 1, 2'd1, 1, 0, 0, 0, 0, 4,   0, 1), 4, 1); drain();
        issue(4'hC, mk(4'hC, 8'h80, 0, 2'd1, 1, 0, 0, 0, 0, 1,   0, 0), 1, 1); drain();
        issue(4'h6, mk(4'h6, 8'h02, 0, 2'd1, 1, 0, 0, 0, 0, 2,   0, 0), 2, 1); drain();
        issue(4'h5, mk(4'h5, 8'h40, 0, 2'd2, 1, 0, 0, 0, 0, 0,   0, 0), 0, 1); drain();
        cond_nz = 1'b1;
        issue(4'h9, mk(4'h9, 8'h0C, 0, 2'd0, 1, 1, 1, 0, 0, 0,   0, 0), 0, 1); drain();
        cond_nz = 1'b0;
        issue(4'h9, mk(4'h9, 8'h0C, 0, 2'd0, 1, 0, 1, 0, 0, 0,   0, 0), 0, 1); drain();
        issue(4'h7, mk(4'h7, 8'h00, 0, 2'd2, 1, 1, 0, 0, 0, 0,   0, 0), 0, 1); drain();
        issue(4'hD, mk(4'hD, 8'h81, 1, 2'd0, 0, 0, 0, 0, 1, 255, 1, 1), 0, 1); drain();
        issue(4'hC, mk(4'hC, 8'h80, 0, 2'd1, 0, 0, 0, 0, 1, 255, 0, 0), 0, 1); drain();
        issue(4'h0, mk(4'h0, 8'h00, 0, 2'd0, 1, 0, 0, 0, 1, 0,   0, 0), 0, 1); drain();

        // Reset while an ldb sits in MEM waiting for an ack that never comes.
        issue(4'hE, mk(4'hE, 8'h81, 1, 2'd1, 1, 0, 0, 0, 1, 0, 0, 1), 0, 0);
        t = 0;
        while (!mem_req && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        check("reset_test_reached_mem", 32'(mem_req), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("memrst_mem_req", 32'(mem_req), 32'd0);
        check("memrst_ins_ready", 32'(ins_ready), 32'd1);
        check("memrst_retire", 32'(retire), 32'd0);
        check("memrst_mem_err", 32'(mem_err), 32'd0);
        check("memrst_rom_opcode", 32'(rom_opcode), 32'd0);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        #1;
        check("memrst_no_pending", 32'(q.size()), 32'd0);

        issue(4'h0, mk(4'h0, 8'h00, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 1); drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
